// File: rtl/if_id_if.sv
// IF/ID pipeline register interface: fetch-side beat in, decode-side beat out, plus flush.
// master = surrounding pipeline (fetch/decode/hazard logic), slave = the if_id_reg block.
interface if_id_if;
    localparam int unsigned XLEN = 32;

    logic            if_valid;
    logic [XLEN-1:0] if_inst;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc_added;
    logic            if_ready;
    logic            flush;
    logic            id_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_inst;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_added;

    modport master (
        output if_valid, if_inst, if_pc, if_pc_added, flush, id_ready,
        input  if_ready, id_valid, id_inst, id_pc, id_pc_added
    );

    modport slave (
        input  if_valid, if_inst, if_pc, if_pc_added, flush, id_ready,
        output if_ready, id_valid, id_inst, id_pc, id_pc_added
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register built as a two-entry skid buffer (main + skid).
// if_ready depends only on registered state, so id_ready never reaches the fetch side
// combinationally. Optional macro IF_ID_BUBBLE_NOP_EN drives NOP_INST on id_inst
// whenever no valid instruction is held.
module if_id_reg #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic     clk,
    input  logic     rst_n,
    if_id_if.slave   bus
);
    localparam int unsigned XLEN = 32;

`ifdef IF_ID_BUBBLE_NOP_EN
    localparam logic [XLEN-1:0] INST_RST = NOP_INST;
`else
    localparam logic [XLEN-1:0] INST_RST = '0;
    wire unused_nop = ^NOP_INST;
`endif

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            ready_q;
    logic            valid_q;
    logic            load_main;
    logic            load_from_skid;
    logic            load_skid;
    logic            xfer_in;
    logic            xfer_out;

    logic [XLEN-1:0] main_inst_q;
    logic [XLEN-1:0] main_pc_q;
    logic [XLEN-1:0] main_pc_added_q;
    logic [XLEN-1:0] skid_inst_q;
    logic [XLEN-1:0] skid_pc_q;
    logic [XLEN-1:0] skid_pc_added_q;

    assign xfer_in  = bus.if_valid & ready_q;
    assign xfer_out = valid_q & bus.id_ready;

    // State, ready and valid registers; ready/valid are precomputed from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != S_SKID);
            valid_q <= (state_d != S_EMPTY);
        end
    end

    // Next-state and register-load decisions; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (xfer_in) begin
                        load_main = 1'b1;
                        state_d   = S_FULL;
                    end
                end
                S_FULL: begin
                    if (xfer_in && xfer_out) begin
                        load_main = 1'b1;
                    end else if (xfer_out) begin
                        state_d = S_EMPTY;
                    end else if (xfer_in) begin
                        load_skid = 1'b1;
                        state_d   = S_SKID;
                    end
                end
                S_SKID: begin
                    if (xfer_out) begin
                        load_from_skid = 1'b1;
                        state_d        = S_FULL;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
        end
    end

    // PC datapath for main and skid entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_pc_q       <= '0;
            main_pc_added_q <= '0;
            skid_inst_q     <= '0;
            skid_pc_q       <= '0;
            skid_pc_added_q <= '0;
        end else begin
            if (load_main) begin
                main_pc_q       <= bus.if_pc;
                main_pc_added_q <= bus.if_pc_added;
            end else if (load_from_skid) begin
                main_pc_q       <= skid_pc_q;
                main_pc_added_q <= skid_pc_added_q;
            end
            if (load_skid) begin
                skid_inst_q     <= bus.if_inst;
                skid_pc_q       <= bus.if_pc;
                skid_pc_added_q <= bus.if_pc_added;
            end
        end
    end

    // Main instruction register; with bubble-NOP enabled it loads NOP whenever going empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_inst_q <= INST_RST;
        end
`ifdef IF_ID_BUBBLE_NOP_EN
        else if (state_d == S_EMPTY) begin
            main_inst_q <= NOP_INST;
        end
`endif
        else if (load_main) begin
            main_inst_q <= bus.if_inst;
        end else if (load_from_skid) begin
            main_inst_q <= skid_inst_q;
        end
    end

    // Outputs come straight from registers.
    assign bus.if_ready    = ready_q;
    assign bus.id_valid    = valid_q;
    assign bus.id_inst     = main_inst_q;
    assign bus.id_pc       = main_pc_q;
    assign bus.id_pc_added = main_pc_added_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed and randomized checks for the IF/ID skid-buffer register.
module tb_if_id_reg;
    localparam logic [31:0] NOP = 32'h00000013;
`ifdef IF_ID_BUBBLE_NOP_EN
    localparam logic [31:0] RST_INST = NOP;
    localparam bit          NOP_EN   = 1'b1;
`else
    localparam logic [31:0] RST_INST = 32'h0;
    localparam bit          NOP_EN   = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    if_id_if bus();

    if_id_reg #(.NOP_INST(NOP)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus.if_valid    = v;
        bus.if_inst     = inst;
        bus.if_pc       = pc;
        bus.if_pc_added = pc + 32'd4;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A0013;
    endfunction

    task automatic test_reset;
        rst_n        = 1'b1;
        bus.flush    = 1'b0;
        bus.id_ready = 1'b0;
        beat(1'b0, 32'h0, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL reset_id_valid got %b exp 0", bus.id_valid); end
        tests++; if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL reset_if_ready got %b exp 0", bus.if_ready); end
        tests++; if (bus.id_pc !== 32'h0) begin fails++; $display("FAIL reset_id_pc got %h exp 0", bus.id_pc); end
        tests++; if (bus.id_pc_added !== 32'h0) begin fails++; $display("FAIL reset_id_pc_added got %h exp 0", bus.id_pc_added); end
        tests++; if (bus.id_inst !== RST_INST) begin fails++; $display("FAIL reset_id_inst got %h exp %h", bus.id_inst, RST_INST); end
        beat(1'b1, 32'hDEADBEEF, 32'h99);
        tick;
        tests++; if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b0) begin fails++; $display("FAIL reset_no_accept got valid=%b ready=%b exp 0/0", bus.id_valid, bus.if_ready); end
        rst_n = 1'b1;
        beat(1'b1, 32'h00500093, 32'h0);
        bus.id_ready = 1'b1;
        tick;
        tests++; if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL release_if_ready got %b exp 1", bus.if_ready); end
        tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL release_id_valid got %b exp 0", bus.id_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] pc;
        logic [31:0] inst;
        tick;
        tests++; if (bus.id_valid !== 1'b1) begin fails++; $display("FAIL first_valid got %b exp 1", bus.id_valid); end
        tests++; if (bus.id_inst !== 32'h00500093) begin fails++; $display("FAIL first_inst got %h exp 00500093", bus.id_inst); end
        tests++; if (bus.id_pc !== 32'h0 || bus.id_pc_added !== 32'h4) begin fails++; $display("FAIL first_pc got %h/%h exp 0/4", bus.id_pc, bus.id_pc_added); end
        for (int i = 1; i <= 4; i++) begin
            pc   = 32'(4 * i);
            inst = 32'h00100093 + 32'(i);
            beat(1'b1, inst, pc);
            tick;
            tests++; if (bus.id_valid !== 1'b1 || bus.if_ready !== 1'b1) begin fails++; $display("FAIL b2b_hs_%0d got valid=%b ready=%b exp 1/1", i, bus.id_valid, bus.if_ready); end
            tests++; if (bus.id_pc !== pc || bus.id_pc_added !== pc + 32'd4) begin fails++; $display("FAIL b2b_pc_%0d got %h/%h exp %h/%h", i, bus.id_pc, bus.id_pc_added, pc, pc + 32'd4); end
            tests++; if (bus.id_inst !== inst) begin fails++; $display("FAIL b2b_inst_%0d got %h exp %h", i, bus.id_inst, inst); end
        end
    endtask

    task automatic test_skid;
        beat(1'b1, 32'h00700093, 32'h14);
        bus.id_ready = 1'b0;
        tick;
        tests++; if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL skid_if_ready got %b exp 0", bus.if_ready); end
        tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h10) begin fails++; $display("FAIL skid_main got valid=%b pc=%h exp 1/10", bus.id_valid, bus.id_pc); end
        beat(1'b1, 32'h00800093, 32'h18);
        bus.id_ready = 1'b1;
        tick;
        beat(1'b0, 32'h0, 32'h0);
        tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h14 || bus.id_pc_added !== 32'h18) begin fails++; $display("FAIL skid_drain got valid=%b pc=%h/%h exp 1/14/18", bus.id_valid, bus.id_pc, bus.id_pc_added); end
        tests++; if (bus.id_inst !== 32'h00700093) begin fails++; $display("FAIL skid_drain_inst got %h exp 00700093", bus.id_inst); end
        tests++; if (bus.if_ready !== 1'b1) begin fails++; $display("FAIL skid_ready_back got %b exp 1", bus.if_ready); end
        tick;
        tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL skid_empty got %b exp 0", bus.id_valid); end
    endtask

    task automatic test_flush;
        logic [31:0] exp_inst;
        exp_inst = NOP_EN ? NOP : 32'h00A00113;
        bus.id_ready = 1'b0;
        beat(1'b1, 32'h00A00113, 32'h20);
        tick;
        beat(1'b1, 32'h00B00193, 32'h24);
        tick;
        tests++; if (bus.if_ready !== 1'b0) begin fails++; $display("FAIL flush_pre_skid got %b exp 0", bus.if_ready); end
        beat(1'b1, 32'h00C00213, 32'h18);
        bus.flush = 1'b1;
        tick;
        bus.flush = 1'b0;
        beat(1'b0, 32'h0, 32'h0);
        tests++; if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1) begin fails++; $display("FAIL flush_state got valid=%b ready=%b exp 0/1", bus.id_valid, bus.if_ready); end
        tests++; if (bus.id_pc !== 32'h20) begin fails++; $display("FAIL flush_pc_hold got %h exp 20", bus.id_pc); end
        tests++; if (bus.id_inst !== exp_inst) begin fails++; $display("FAIL flush_inst got %h exp %h", bus.id_inst, exp_inst); end
        tick;
        tests++; if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h20) begin fails++; $display("FAIL flush_after got valid=%b pc=%h exp 0/20", bus.id_valid, bus.id_pc); end
    endtask

    task automatic test_flush_with_ready;
        beat(1'b1, 32'h00D00293, 32'h30);
        tick;
        tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h30) begin fails++; $display("FAIL fr_load got valid=%b pc=%h exp 1/30", bus.id_valid, bus.id_pc); end
        beat(1'b1, 32'h00D00313, 32'h34);
        bus.id_ready = 1'b1;
        bus.flush    = 1'b1;
        tick;
        bus.flush    = 1'b0;
        bus.id_ready = 1'b0;
        beat(1'b0, 32'h0, 32'h0);
        tests++; if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1) begin fails++; $display("FAIL fr_state got valid=%b ready=%b exp 0/1", bus.id_valid, bus.if_ready); end
        tick;
        tests++; if (bus.id_valid !== 1'b0 || bus.id_pc === 32'h34) begin fails++; $display("FAIL fr_dropped got valid=%b pc=%h exp 0/not 34", bus.id_valid, bus.id_pc); end
    endtask

    task automatic test_async_reset;
        beat(1'b1, 32'h00E00313, 32'h40);
        tick;
        tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h40) begin fails++; $display("FAIL ar_full got valid=%b pc=%h exp 1/40", bus.id_valid, bus.id_pc); end
        beat(1'b1, 32'h00F00393, 32'h44);
        #3 rst_n = 1'b0;
        #1;
        tests++; if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b0) begin fails++; $display("FAIL ar_immediate got valid=%b ready=%b exp 0/0", bus.id_valid, bus.if_ready); end
        tests++; if (bus.id_pc !== 32'h0 || bus.id_inst !== RST_INST) begin fails++; $display("FAIL ar_data got pc=%h inst=%h exp 0/%h", bus.id_pc, bus.id_inst, RST_INST); end
        tick;
        tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL ar_hold got %b exp 0", bus.id_valid); end
        #2 rst_n = 1'b1;
        tick;
        tests++; if (bus.if_ready !== 1'b1 || bus.id_valid !== 1'b0) begin fails++; $display("FAIL ar_release got ready=%b valid=%b exp 1/0", bus.if_ready, bus.id_valid); end
        tick;
        beat(1'b0, 32'h0, 32'h0);
        tests++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h44 || bus.id_inst !== 32'h00F00393) begin fails++; $display("FAIL ar_first got valid=%b pc=%h inst=%h exp 1/44/00f00393", bus.id_valid, bus.id_pc, bus.id_inst); end
        bus.id_ready = 1'b1;
        tick;
        tests++; if (bus.id_valid !== 1'b0) begin fails++; $display("FAIL ar_drain got %b exp 0", bus.id_valid); end
    endtask

    task automatic test_random;
        logic [31:0] next_pc;
        logic [31:0] exp_pc;
        logic [31:0] got_pc;
        logic [31:0] got_pa;
        logic [31:0] got_inst;
        logic        acc;
        logic        cons;
        next_pc = 32'h1000;
        exp_pc  = 32'h1000;
        for (int c = 0; c < 10004; c++) begin
            if (c < 10000) begin
                bus.if_valid = 1'($urandom_range(0, 1));
                bus.id_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.if_valid = 1'b0;
                bus.id_ready = 1'b1;
            end
            bus.if_pc       = next_pc;
            bus.if_pc_added = next_pc + 32'd4;
            bus.if_inst     = inst_of(next_pc);
            acc      = bus.if_valid & bus.if_ready;
            cons     = bus.id_valid & bus.id_ready;
            got_pc   = bus.id_pc;
            got_pa   = bus.id_pc_added;
            got_inst = bus.id_inst;
            tick;
            if (cons) begin
                tests++;
                if (got_pc !== exp_pc || got_pa !== exp_pc + 32'd4 || got_inst !== inst_of(exp_pc)) begin
                    fails++;
                    $display("FAIL rand_order got pc=%h pa=%h inst=%h exp %h/%h/%h", got_pc, got_pa, got_inst, exp_pc, exp_pc + 32'd4, inst_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (acc) next_pc = next_pc + 32'd4;
        end
        tests++; if (exp_pc !== next_pc || bus.id_valid !== 1'b0) begin fails++; $display("FAIL rand_complete got consumed_to=%h valid=%b exp %h/0", exp_pc, bus.id_valid, next_pc); end
        tests++; if (exp_pc - 32'h1000 < 32'd4000) begin fails++; $display("FAIL rand_throughput got %0d beats exp >= 1000", (exp_pc - 32'h1000) / 4); end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_skid;
        test_flush;
        test_flush_with_ready;
        test_async_reset;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
